// File: rtl/econet_rx_frame_queue.sv
// Econet receive queue: deframed bytes go into a circular byte buffer, and accepted frames are queued as descriptors for the CPU.
// Define ECONET_RX_BCAST_EN to also accept broadcast frames (destination 16'hFFFF).
module econet_rx_frame_queue #(
  parameter int          BUF_BYTES  = 1024,
  parameter int          PTR_W      = 10,
  parameter int          DESC_DEPTH = 4,
  parameter int          DESC_W     = 2,
  parameter logic [15:0] FCS_GOOD   = 16'hF0B8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_ready,
  input  logic        rx_frame_start,
  input  logic        rx_frame_end,
  input  logic [15:0] rx_fcs,
  input  logic        sys_rd,
  input  logic [3:0]  sys_wr,
  input  logic        sys_buf_select,
  input  logic        sys_reg_select,
  input  logic [7:0]  sys_addr,
  input  logic [31:0] sys_wdata,
  output logic [31:0] sys_rdata,
  output logic        sys_frame_valid,
  output logic        receiving
);
  localparam int WA    = PTR_W - 2;
  localparam int WORDS = BUF_BYTES / 4;
  localparam int CW    = DESC_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [DESC_W-1:0] IDX_ONE  = DESC_W'(1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DESC_DEPTH);

  logic [31:0]       mem_q [WORDS];
  logic [PTR_W-1:0]  desc_start_q [DESC_DEPTH];
  logic [PTR_W-1:0]  desc_end_q   [DESC_DEPTH];
  logic [PTR_W-1:0]  desc_cnt_q   [DESC_DEPTH];
  logic [31:0]       desc_addr_q  [DESC_DEPTH];
  logic [15:0]       desc_scout_q [DESC_DEPTH];
  logic              desc_bcast_q [DESC_DEPTH];

  logic              receiving_q, receiving_d, ovf_q, ovf_d, overrun_q, overrun_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, frame_start_q, frame_start_d;
  logic [PTR_W-1:0]  frame_cnt_q, frame_cnt_d, free_ptr_q, free_ptr_d;
  logic [7:0]        hdr_q [8];
  logic [7:0]        hdr_d [8];
  logic [7:0]        drop_cnt_q, drop_cnt_d, our_stn_q, our_stn_d, our_net_q, our_net_d;
  logic [DESC_W-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [31:0]       buf_rd_q, buf_rd_d;

  logic              fifo_empty, fifo_full, dst_match, bcast_dst, frame_ok;
  logic              reg_wr, pop, push, byte_wr;
  logic [15:0]       dst;
  logic [PTR_W-1:0]  wr_ptr_inc, free_lim;
  logic [31:0]       reg_rdata;
  logic              unused_wdata;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_FULL);
  assign dst        = {hdr_q[1], hdr_q[0]};
  assign dst_match  = (dst == {our_net_q, our_stn_q});
`ifdef ECONET_RX_BCAST_EN
  assign bcast_dst  = (dst == 16'hFFFF);
`else
  assign bcast_dst  = 1'b0;
`endif
  assign frame_ok   = (rx_fcs == FCS_GOOD) && (dst_match || bcast_dst) &&
                      (frame_cnt_q >= PTR_W'(6)) && !ovf_q && !fifo_full;
  assign reg_wr     = sys_reg_select && (|sys_wr);
  assign pop        = reg_wr && sys_wr[0] && (sys_addr == 8'd7) && sys_wdata[0] && !fifo_empty;
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  // With no frame held, the only data to protect is the frame being received.
  assign free_lim   = fifo_empty ? frame_start_q : free_ptr_q;
  assign unused_wdata = ^sys_wdata[30:16];

  always_comb begin
    receiving_d   = receiving_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    ovf_d         = ovf_q;
    hdr_d         = hdr_q;
    overrun_d     = overrun_q;
    drop_cnt_d    = drop_cnt_q;
    our_stn_d     = our_stn_q;
    our_net_d     = our_net_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_cnt_d    = fifo_cnt_q;
    free_ptr_d    = free_ptr_q;
    buf_rd_d      = buf_rd_q;
    byte_wr       = 1'b0;
    push          = 1'b0;

    if (sys_rd && sys_buf_select) buf_rd_d = mem_q[sys_addr[WA-1:0]];
    if (reg_wr && sys_addr == 8'd6) begin
      if (sys_wr[0]) our_stn_d = sys_wdata[7:0];
      if (sys_wr[1]) our_net_d = sys_wdata[15:8];
    end
    if (reg_wr && sys_addr == 8'd7) begin
      if (sys_wr[0] && sys_wdata[2])  overrun_d  = 1'b0;
      if (sys_wr[3] && sys_wdata[31]) drop_cnt_d = 8'd0;
    end

    // A restart rewinds any partial frame and reuses its space.
    if (rx_frame_start) begin
      wr_ptr_d      = receiving_q ? frame_start_q : wr_ptr_q;
      frame_start_d = receiving_q ? frame_start_q : wr_ptr_q;
      receiving_d   = 1'b1;
      frame_cnt_d   = '0;
      ovf_d         = 1'b0;
    end else if (rx_frame_end && receiving_q) begin
      receiving_d = 1'b0;
      if (frame_ok) begin
        push = 1'b1;
      end else begin
        wr_ptr_d = frame_start_q;
        if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
        if (fifo_full || ovf_q) overrun_d = 1'b1;
      end
    end else if (rx_byte_ready && receiving_q && !ovf_q) begin
      if (wr_ptr_inc == free_lim) begin
        ovf_d = 1'b1;
      end else begin
        byte_wr     = 1'b1;
        wr_ptr_d    = wr_ptr_inc;
        frame_cnt_d = frame_cnt_q + PTR_ONE;
        if (frame_cnt_q < PTR_W'(6)) hdr_d[frame_cnt_q[2:0]] = rx_byte;
      end
    end

    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    if (push) fifo_wr_d = fifo_wr_q + IDX_ONE;
    if (pop) begin
      fifo_rd_d  = fifo_rd_q + IDX_ONE;
      free_ptr_d = desc_end_q[fifo_rd_q];
    end else if (fifo_empty) begin
      free_ptr_d = frame_start_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    hdr_q <= hdr_d;
    if (reset) begin
      receiving_q   <= 1'b0;
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      frame_cnt_q   <= '0;
      ovf_q         <= 1'b0;
      overrun_q     <= 1'b0;
      drop_cnt_q    <= 8'd0;
      our_stn_q     <= 8'd0;
      our_net_q     <= 8'd0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_cnt_q    <= '0;
      free_ptr_q    <= '0;
      buf_rd_q      <= 32'd0;
    end else begin
      receiving_q   <= receiving_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      ovf_q         <= ovf_d;
      overrun_q     <= overrun_d;
      drop_cnt_q    <= drop_cnt_d;
      our_stn_q     <= our_stn_d;
      our_net_q     <= our_net_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      free_ptr_q    <= free_ptr_d;
      buf_rd_q      <= buf_rd_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (byte_wr && !reset) mem_q[wr_ptr_q[PTR_W-1:2]][{wr_ptr_q[1:0], 3'b000} +: 8] <= rx_byte;
    if (push && !reset) begin
      desc_start_q[fifo_wr_q] <= frame_start_q;
      desc_end_q[fifo_wr_q]   <= wr_ptr_q;
      desc_cnt_q[fifo_wr_q]   <= frame_cnt_q;
      desc_addr_q[fifo_wr_q]  <= {hdr_q[3], hdr_q[2], hdr_q[1], hdr_q[0]};
      desc_scout_q[fifo_wr_q] <= {hdr_q[4], hdr_q[5]};
      desc_bcast_q[fifo_wr_q] <= bcast_dst;
    end
  end

  always_comb begin
    reg_rdata = 32'h5555_5555;
    case (sys_addr)
      8'd0: reg_rdata = fifo_empty ? 32'd0 : 32'(desc_start_q[fifo_rd_q]);
      8'd1: reg_rdata = fifo_empty ? 32'd0 : 32'(desc_end_q[fifo_rd_q]);
      8'd2: reg_rdata = fifo_empty ? 32'd0 : 32'(desc_cnt_q[fifo_rd_q]);
      8'd3: reg_rdata = fifo_empty ? 32'd0 : desc_addr_q[fifo_rd_q];
      8'd4: reg_rdata = fifo_empty ? 32'd0 :
                        {desc_addr_q[fifo_rd_q][15:0], desc_addr_q[fifo_rd_q][31:16]};
      8'd5: reg_rdata = fifo_empty ? 32'd0 : {16'd0, desc_scout_q[fifo_rd_q]};
      8'd6: reg_rdata = {16'd0, our_net_q, our_stn_q};
      8'd7: reg_rdata = {drop_cnt_q, 13'd0, 3'(fifo_cnt_q), 4'd0,
                         !fifo_empty && desc_bcast_q[fifo_rd_q], overrun_q, receiving_q, !fifo_empty};
      default: reg_rdata = 32'h5555_5555;
    endcase
  end

  assign sys_rdata       = sys_buf_select ? buf_rd_q : reg_rdata;
  assign sys_frame_valid = !fifo_empty;
  assign receiving       = receiving_q;
endmodule

// File: tb/tb_econet_rx_frame_queue.sv
// Directed bench for econet_rx_frame_queue: frame accept/reject, descriptor FIFO, overflow, abort, reset.
module tb_econet_rx_frame_queue;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_byte_ready = 1'b0, rx_frame_start = 1'b0, rx_frame_end = 1'b0;
  logic [15:0] rx_fcs = 16'd0;
  logic        sys_rd = 1'b0, sys_buf_select = 1'b0, sys_reg_select = 1'b0;
  logic [3:0]  sys_wr = 4'd0;
  logic [7:0]  sys_addr = 8'd0;
  logic [31:0] sys_wdata = 32'd0;
  logic [31:0] sys_rdata;
  logic        sys_frame_valid, receiving;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [15:0] GOOD = 16'hF0B8;

  econet_rx_frame_queue dut (
    .sys_clk(sys_clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_ready(rx_byte_ready),
    .rx_frame_start(rx_frame_start), .rx_frame_end(rx_frame_end), .rx_fcs(rx_fcs),
    .sys_rd(sys_rd), .sys_wr(sys_wr), .sys_buf_select(sys_buf_select),
    .sys_reg_select(sys_reg_select), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_rdata(sys_rdata), .sys_frame_valid(sys_frame_valid), .receiving(receiving)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
    sys_buf_select = 1'b0;
    sys_addr = a;
    #1;
    check_val(tag, sys_rdata, exp);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [3:0] lanes, input logic [31:0] d);
    sys_reg_select = 1'b1; sys_addr = a; sys_wr = lanes; sys_wdata = d;
    tick();
    sys_reg_select = 1'b0; sys_wr = 4'd0; sys_wdata = 32'd0;
  endtask

  task automatic pop();
    reg_write(8'd7, 4'h1, 32'h1);
  endtask

  function automatic logic [7:0] fbyte(input int i, input logic [7:0] ds, input logic [7:0] dn);
    case (i)
      0: return ds;
      1: return dn;
      2: return 8'h05;
      3: return 8'h06;
      4: return 8'h80;
      5: return 8'h99;
      default: return 8'(i);
    endcase
  endfunction

  task automatic start_frame();
    rx_frame_start = 1'b1;
    tick();
    rx_frame_start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] ds, input logic [7:0] dn, input int len);
    for (int i = 0; i < len; i++) begin
      rx_byte = fbyte(i, ds, dn);
      rx_byte_ready = 1'b1;
      tick();
    end
    rx_byte_ready = 1'b0;
  endtask

  task automatic end_frame(input logic [15:0] fcs);
    rx_fcs = fcs;
    rx_frame_end = 1'b1;
    tick();
    rx_frame_end = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ds, input logic [7:0] dn, input int len, input logic [15:0] fcs);
    start_frame();
    send_bytes(ds, dn, len);
    end_frame(fcs);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    tick();
    check_val("reset_valid", 32'(sys_frame_valid), 32'd0);
    check_val("reset_receiving", 32'(receiving), 32'd0);
    check_reg("reset_status", 8'd7, 32'h0);
    check_reg("reset_our", 8'd6, 32'h0);
    sys_buf_select = 1'b1; #1;
    check_val("reset_bufreg", sys_rdata, 32'h0);
    sys_buf_select = 1'b0;

    reg_write(8'd6, 4'h3, 32'h0000_0102);
    check_reg("our_addr", 8'd6, 32'h0000_0102);

    // first good frame
    start_frame();
    check_val("receiving_mid", 32'(receiving), 32'd1);
    send_bytes(8'h02, 8'h01, 10);
    end_frame(GOOD);
    check_val("valid_after_good", 32'(sys_frame_valid), 32'd1);
    check_val("receiving_after_end", 32'(receiving), 32'd0);
    check_reg("a_start", 8'd0, 32'd0);
    check_reg("a_end", 8'd1, 32'd10);
    check_reg("a_count", 8'd2, 32'd10);
    check_reg("a_address", 8'd3, 32'h0605_0102);
    check_reg("a_reply", 8'd4, 32'h0102_0605);
    check_reg("a_scout", 8'd5, 32'h0000_8099);
    check_reg("a_status", 8'd7, 32'h0000_0101);
    sys_buf_select = 1'b1; sys_rd = 1'b1; sys_addr = 8'd1;
    tick();
    sys_rd = 1'b0;
    check_val("buf_word1", sys_rdata, 32'h0706_9980);
    sys_addr = 8'd0; #1;
    check_val("buf_hold", sys_rdata, 32'h0706_9980);
    sys_rd = 1'b1;
    tick();
    sys_rd = 1'b0;
    check_val("buf_word0", sys_rdata, 32'h0605_0102);
    sys_buf_select = 1'b0;

    // three queued frames, popped in order
    send_frame(8'h02, 8'h01, 10, GOOD);
    send_frame(8'h02, 8'h01, 10, GOOD);
    check_reg("three_status", 8'd7, 32'h0000_0301);
    check_reg("pop1_start", 8'd0, 32'd0);
    pop();
    check_reg("pop2_start", 8'd0, 32'd10);
    pop();
    check_reg("pop3_start", 8'd0, 32'd20);
    pop();
    check_val("valid_after_pops", 32'(sys_frame_valid), 32'd0);
    check_reg("empty_end_zero", 8'd1, 32'd0);

    // bad FCS rewinds
    send_frame(8'h02, 8'h01, 10, 16'h1234);
    check_val("badfcs_valid", 32'(sys_frame_valid), 32'd0);
    check_reg("badfcs_status", 8'd7, 32'h0100_0000);
    send_frame(8'h02, 8'h01, 10, GOOD);
    check_reg("after_bad_start", 8'd0, 32'd30);
    check_reg("after_bad_end", 8'd1, 32'd40);
    pop();
    pop();
    check_reg("pop_empty_status", 8'd7, 32'h0100_0000);
    reg_write(8'd7, 4'h8, 32'h8000_0000);
    check_reg("drop_cleared", 8'd7, 32'h0);

    // FIFO full: fifth frame dropped
    for (int k = 0; k < 5; k++) send_frame(8'h02, 8'h01, 8, GOOD);
    check_reg("full_status", 8'd7, 32'h0100_0405);
    for (int k = 0; k < 4; k++) begin
      check_reg($sformatf("full_start%0d", k), 8'd0, 32'(40 + 8 * k));
      pop();
    end
    reg_write(8'd7, 4'h9, 32'h8000_0004);
    check_reg("full_cleared", 8'd7, 32'h0);

    // abort after 3 bytes, restart
    start_frame();
    send_bytes(8'h02, 8'h01, 3);
    send_frame(8'h02, 8'h01, 8, GOOD);
    check_reg("abort_status", 8'd7, 32'h0000_0101);
    check_reg("abort_start", 8'd0, 32'd72);
    check_reg("abort_count", 8'd2, 32'd8);
    check_reg("abort_end", 8'd1, 32'd80);
    pop();

    // overflow: 500 held, 600 more does not fit
    send_frame(8'h02, 8'h01, 500, GOOD);
    send_frame(8'h02, 8'h01, 600, GOOD);
    check_reg("ovf_status", 8'd7, 32'h0100_0105);
    check_reg("ovf_head_start", 8'd0, 32'd80);
    check_reg("ovf_head_end", 8'd1, 32'd580);
    pop();
    reg_write(8'd7, 4'h9, 32'h8000_0004);

    // broadcast
    send_frame(8'hFF, 8'hFF, 8, GOOD);
`ifdef ECONET_RX_BCAST_EN
    check_reg("bcast_status", 8'd7, 32'h0000_0109);
    check_reg("bcast_start", 8'd0, 32'd580);
    pop();
`else
    check_reg("bcast_status", 8'd7, 32'h0100_0000);
    check_val("bcast_valid", 32'(sys_frame_valid), 32'd0);
`endif

    // reset mid-frame
    start_frame();
    send_bytes(8'h02, 8'h01, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rst_mid_valid", 32'(sys_frame_valid), 32'd0);
    check_val("rst_mid_receiving", 32'(receiving), 32'd0);
    check_reg("rst_mid_status", 8'd7, 32'h0);
    reg_write(8'd6, 4'h3, 32'h0000_0102);
    send_frame(8'h02, 8'h01, 10, GOOD);
    check_reg("rst_next_start", 8'd0, 32'd0);
    check_reg("rst_next_end", 8'd1, 32'd10);
    pop();

    // short and misaddressed frames dropped, idle end ignored
    send_frame(8'h02, 8'h01, 4, GOOD);
    send_frame(8'h03, 8'h01, 10, GOOD);
    check_reg("short_wrongdst_status", 8'd7, 32'h0200_0000);
    end_frame(GOOD);
    check_reg("idle_end_status", 8'd7, 32'h0200_0000);
    check_val("idle_end_valid", 32'(sys_frame_valid), 32'd0);
    check_reg("unmapped", 8'd9, 32'h5555_5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
